vga_fb_arbiter: RTL

// - Shares one single-port synchronous framebuffer RAM between VGA scanout and ASIP CPU writes.
// - Sits between the VGA timing counters (posx/posy/Blank_n) and the video RAM; emits the current pixel.
// - Scanout has hard priority in fixed slots; CPU writes go through a small buffer and drain in free slots.
// - Framebuffer is FB_W x FB_H, pixel-doubled in x and y onto the 640x480 active area.

---
 rtl/vga_fb_pkg.sv | 26 ++
 rtl/vga_fb_arbiter_fifo.sv | 53 +++++
 rtl/vga_fb_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/vga_fb_pkg.sv
// Shared constants and types for the VGA framebuffer arbiter: framebuffer geometry,
// 640x480 active-area timing origin, and the per-cycle RAM slot owner encoding.
package vga_fb_pkg;

  localparam int unsigned FB_W     = 320;
  localparam int unsigned FB_H     = 240;
  localparam int unsigned DW       = 8;
  localparam int unsigned AW       = 17;
  localparam int unsigned DEPTH    = 4;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned HSS      = 144;
  localparam int unsigned VSS      = 35;

  typedef logic [AW-1:0] fb_addr_t;
  typedef logic [DW-1:0] pixel_t;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_DISP,
    SLOT_CPUW,
    SLOT_CPUR
  } slot_e;

endpackage

// File: rtl/vga_fb_arbiter_fifo.sv
// fb_wr_fifo: DEPTH-entry synchronous FIFO buffering CPU framebuffer writes ({addr, data}).
// Push is ignored when full, pop is ignored when empty; push and pop may share a cycle.
module fb_wr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 25
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [W-1:0]           din_i,
  input  logic                   pop_i,
  output logic [W-1:0]           dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rp_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wp_d  = wp_q + PW'(do_push);
    rp_d  = rp_q + PW'(do_pop);
    cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wp_q] <= din_i;
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares a single-port framebuffer RAM between pixel-doubled VGA scanout
// (even-column slots) and buffered CPU writes. Define VGA_FB_CPU_READ_EN for CPU reads.
module vga_fb_arbiter #(
  parameter int unsigned FB_W  = vga_fb_pkg::FB_W,
  parameter int unsigned FB_H  = vga_fb_pkg::FB_H,
  parameter int unsigned DW    = vga_fb_pkg::DW,
  parameter int unsigned AW    = vga_fb_pkg::AW,
  parameter int unsigned DEPTH = vga_fb_pkg::DEPTH,
  parameter int unsigned HSS   = vga_fb_pkg::HSS,
  parameter int unsigned VSS   = vga_fb_pkg::VSS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    posx,
  input  logic [9:0]    posy,
  input  logic          Blank_n,
  input  logic          cpu_valid,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
`ifdef VGA_FB_CPU_READ_EN
  input  logic          cpu_rd,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
`endif
  output logic          cpu_ready,
  output logic          cpu_err,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [DW-1:0] pixel
);
  import vga_fb_pkg::*;

  localparam int unsigned CW        = $clog2(DEPTH) + 1;
  localparam logic [AW:0] NPIX      = (AW+1)'(FB_W * FB_H);

  logic signed [11:0] rx, ry;
  logic               disp_slot;
  logic [AW:0]        disp_addr;
  slot_e              slot;

  logic               buf_full, buf_empty, buf_pop, wr_acc, rd_acc, acc_bad;
  logic [CW-1:0]      buf_cnt;
  logic [AW-1:0]      head_addr;
  logic [DW-1:0]      head_data;
  logic               head_ok;

  logic [DW-1:0]      pix_q;
  logic               disp_vld_q;
  logic               cpu_err_q, cpu_err_d;
  logic               unused_bits;

  assign rx = $signed({2'b00, posx}) - $signed(12'(HSS));
  assign ry = $signed({2'b00, posy}) - $signed(12'(VSS));

  // Each even slot fetches the pixel shown two columns later, hence the +2 lead.
  assign disp_slot = (ry >= 12'sd0) && (ry < $signed(12'(V_ACTIVE))) &&
                     (rx >= -12'sd2) && (rx < $signed(12'(H_ACTIVE - 2))) && !rx[0];
  assign disp_addr = (AW+1)'(ry >>> 1) * (AW+1)'(FB_W) + (AW+1)'((rx + 12'sd2) >>> 1);

  assign head_ok   = ({1'b0, head_addr} < NPIX);
  assign acc_bad   = ({1'b0, cpu_addr} >= NPIX);

`ifdef VGA_FB_CPU_READ_EN
  logic          rd_pend_q, rd_issue_q, rd_bad_q;
  logic [AW-1:0] rd_addr_q;
  logic          rd_busy;

  assign rd_busy    = rd_pend_q | rd_issue_q;
  assign cpu_ready  = !rd_busy && (cpu_rd ? buf_empty : !buf_full);
  assign wr_acc     = cpu_valid & cpu_ready & ~cpu_rd;
  assign rd_acc     = cpu_valid & cpu_ready & cpu_rd;
  assign cpu_rvalid = rd_issue_q;
  assign cpu_rdata  = rd_bad_q ? '0 : ram_rdata;
`else
  assign cpu_ready  = !buf_full;
  assign wr_acc     = cpu_valid & cpu_ready;
  assign rd_acc     = 1'b0;
`endif

  fb_wr_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + DW)
  ) u_wr_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (wr_acc),
    .din_i   ({cpu_addr, cpu_wdata}),
    .pop_i   (buf_pop),
    .dout_o  ({head_addr, head_data}),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .count_o (buf_cnt)
  );

  assign unused_bits = ^{buf_cnt, disp_addr[AW]};

  always_comb begin
    slot = SLOT_IDLE;
    if (rst)                slot = SLOT_IDLE;
    else if (disp_slot)     slot = SLOT_DISP;
`ifdef VGA_FB_CPU_READ_EN
    else if (rd_pend_q)     slot = SLOT_CPUR;
`endif
    else if (!buf_empty)    slot = SLOT_CPUW;
  end

  assign buf_pop = (slot == SLOT_CPUW);

  // A popped out-of-range head is retired without touching the RAM.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (slot)
      SLOT_DISP: begin
        ram_en   = 1'b1;
        ram_addr = disp_addr[AW-1:0];
      end
      SLOT_CPUW: begin
        if (head_ok) begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = head_addr;
          ram_wdata = head_data;
        end
      end
`ifdef VGA_FB_CPU_READ_EN
      SLOT_CPUR: begin
        if (!rd_bad_q) begin
          ram_en   = 1'b1;
          ram_addr = rd_addr_q;
        end
      end
`endif
      default: ;
    endcase
  end

  assign cpu_err_d = cpu_err_q | ((wr_acc | rd_acc) & acc_bad);
  assign cpu_err   = cpu_err_q;
  assign pixel     = Blank_n ? pix_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q      <= '0;
      disp_vld_q <= 1'b0;
      cpu_err_q  <= 1'b0;
    end else begin
      disp_vld_q <= (slot == SLOT_DISP);
      if (disp_vld_q) pix_q <= ram_rdata;
      cpu_err_q  <= cpu_err_d;
    end
  end

`ifdef VGA_FB_CPU_READ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_q  <= 1'b0;
      rd_issue_q <= 1'b0;
      rd_bad_q   <= 1'b0;
      rd_addr_q  <= '0;
    end else begin
      rd_issue_q <= (slot == SLOT_CPUR);
      if (rd_acc) begin
        rd_pend_q <= 1'b1;
        rd_addr_q <= cpu_addr;
        rd_bad_q  <= acc_bad;
      end else if (slot == SLOT_CPUR) begin
        rd_pend_q <= 1'b0;
      end
    end
  end
`endif

endmodule
